// File: rtl/bcd_seg7_scan_if.sv
// Bus between the BCD converter side and the 7-segment scanner.
// Handshake: there is no back-pressure. 'load' is a single-cycle strobe.
// When 'load' is high at a rising clk edge, 'bcd_in' is captured on that
// edge. No ready signal exists because every load is accepted. The
// scanner-side outputs are all registered.
// dbg_idx and dbg_pend_flag expose the scan position and the
// pending-buffer flag so that checkers can be bound to them.
interface bcd_seg7_scan_if;
    logic        load;
    logic [27:0] bcd_in;
    logic [6:0]  an;
    logic [6:0]  seg;
    logic        frame_done;
    logic [2:0]  dbg_idx;
    logic        dbg_pend_flag;

    // Source of BCD digits (converter / testbench side)
    modport master (
        output load,
        output bcd_in,
        input  an,
        input  seg,
        input  frame_done,
        input  dbg_idx,
        input  dbg_pend_flag
    );

    // Display scanner side
    modport slave (
        input  load,
        input  bcd_in,
        output an,
        output seg,
        output frame_done,
        output dbg_idx,
        output dbg_pend_flag
    );
endinterface

// File: rtl/bcd_seg7_scan.sv
// Seven-digit common-anode 7-segment scanner with a double-buffered frame.
//
// The scanner drives one digit per scan slot of PRESCALE clocks. The slot
// index runs 0..6, with ones first and millions last. New digits are first
// captured into a pending register. They move to the active register only
// when the scan wraps from digit 6 to digit 0, so a frame never mixes old
// and new values.
//
// When the scanner moves to a new slot, the outputs stay blank for one
// cycle so the previous digit does not ghost onto the next anode.
//
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN: when this macro is
// defined, leading zero digits are blanked. The anode for a blanked digit
// is still asserted. The ones digit is never blanked.
module bcd_seg7_scan #(
    parameter int PRESCALE   = 50000,
    parameter int PRESCALE_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    bcd_seg7_scan_if.slave bus
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [2:0]            LAST_IDX      = 3'd6;
    localparam logic [6:0]            BLANK         = 7'h7F;

    // Segment pattern {g,f,e,d,c,b,a}, active-low. Non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // State registers
    logic [PRESCALE_W-1:0] presc_q;
    logic [2:0]            idx_q;
    logic [27:0]           pend_q;
    logic                  pend_flag_q;
    logic [27:0]           active_q;
    logic [6:0]            an_q;
    logic [6:0]            seg_q;
    logic                  frame_done_q;

    // Next-state values
    logic [PRESCALE_W-1:0] presc_d;
    logic [2:0]            idx_d;
    logic [27:0]           pend_d;
    logic                  pend_flag_d;
    logic [27:0]           active_d;
    logic [6:0]            an_d;
    logic [6:0]            seg_d;
    logic                  frame_done_d;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            cur_digit;
    logic [6:0]            one_hot;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [6:0]            lead_zero;
    logic                  zero_run;
`endif

    assign tick      = (presc_q == PRESCALE_LAST);
    assign wrap      = tick && (idx_q == LAST_IDX);
    assign cur_digit = active_q[{idx_q, 2'b00} +: 4];
    assign one_hot   = 7'b1 << idx_q;

    // Next-state: prescaler, scan index, buffering and the registered output stage
    always_comb begin
        presc_d      = presc_q + PRESCALE_W'(1);
        idx_d        = idx_q;
        pend_d       = pend_q;
        pend_flag_d  = pend_flag_q;
        active_d     = active_q;
        an_d         = ~one_hot;
        seg_d        = seg_decode(cur_digit);
        frame_done_d = wrap;

        if (tick) begin
            presc_d = '0;
            idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end

        // The last load wins. A load always refreshes the pending copy.
        if (bus.load) begin
            pend_d      = bus.bcd_in;
            pend_flag_d = 1'b1;
        end

        // Frame boundary: a load on this same edge bypasses the pending stage
        if (wrap) begin
            if (bus.load) begin
                active_d    = bus.bcd_in;
                pend_flag_d = 1'b0;
            end else if (pend_flag_q) begin
                active_d    = pend_q;
                pend_flag_d = 1'b0;
            end
        end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // lead_zero[k] is set when digits k..6 of the active frame are all zero
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int k = 6; k >= 0; k--) begin
            zero_run     = zero_run && (active_q[k*4 +: 4] == 4'd0);
            lead_zero[k] = zero_run;
        end
        if ((idx_q != 3'd0) && lead_zero[idx_q]) begin
            seg_d = BLANK;
        end
`endif

        // Anti-ghost blank cycle at every slot change
        if (tick) begin
            an_d  = BLANK;
            seg_d = BLANK;
        end
    end

    // Register update with asynchronous reset to a blank, idle display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= 3'd0;
            pend_q       <= '0;
            pend_flag_q  <= 1'b0;
            active_q     <= '0;
            an_q         <= BLANK;
            seg_q        <= BLANK;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            active_q     <= active_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an            = an_q;
    assign bus.seg           = seg_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.dbg_idx       = idx_q;
    assign bus.dbg_pend_flag = pend_flag_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Directed testbench for bcd_seg7_scan with PRESCALE=4, so one frame is 28 clocks.
// Expected segment codes are written out by hand for each frame.
// Define SEG7_LEADING_ZERO_BLANK_EN to check the leading-zero blanking build.
module tb_bcd_seg7_scan;

    // Clock and reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_seg7_scan_if bus ();

    bcd_seg7_scan #(
        .PRESCALE   (4),
        .PRESCALE_W (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pattern for a zero digit in a position that leading-zero blanking may hide
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one frame (or its first n_cyc cycles) and checks every cycle.
    // The frame starts just after the edge that ended the previous frame.
    // exp_seg[7k +: 7] is the expected segment code for digit k.
    // If load_i >= 0, load is pulsed in iteration load_i. The value is
    // therefore captured on edge load_i+1 of the frame.
    task automatic run_frame(input string name, input logic [48:0] exp_seg,
                             input int load_i, input logic [27:0] load_val,
                             input int n_cyc);
        logic [6:0] one;
        logic [6:0] e_an;
        logic [6:0] e_seg;
        int slot;
        int phase;
        one = 7'b1;
        for (int i = 0; i < n_cyc; i++) begin
            if (i == load_i) begin
                bus.load   = 1'b1;
                bus.bcd_in = load_val;
            end else begin
                bus.load   = 1'b0;
                bus.bcd_in = 28'($urandom);
            end
            @(posedge clk);
            #1;
            slot  = i / 4;
            phase = i % 4;
            if (phase == 3) begin
                e_an  = 7'h7F;
                e_seg = 7'h7F;
            end else begin
                e_an  = ~(one << slot);
                e_seg = exp_seg[slot*7 +: 7];
            end
            check($sformatf("%s an c%0d", name, i), {25'd0, bus.an}, {25'd0, e_an});
            check($sformatf("%s seg c%0d", name, i), {25'd0, bus.seg}, {25'd0, e_seg});
            check($sformatf("%s frame_done c%0d", name, i), {31'd0, bus.frame_done},
                  {31'd0, (i == 27)});
            check($sformatf("%s idx c%0d", name, i), {29'd0, bus.dbg_idx},
                  32'(((i + 1) / 4) % 7));
        end
        bus.load = 1'b0;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        bus.load   = 1'b0;
        bus.bcd_in = 28'h0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset an", {25'd0, bus.an}, 32'h7F);
        check("reset seg", {25'd0, bus.seg}, 32'h7F);
        check("reset frame_done", {31'd0, bus.frame_done}, 32'h0);
        check("reset idx", {29'd0, bus.dbg_idx}, 32'h0);
        check("reset pend", {31'd0, bus.dbg_pend_flag}, 32'h0);
        rst = 1'b0;

        // Idle zeros. A mid-frame load must not disturb the current frame.
        run_frame("zeros", {LZ, LZ, LZ, LZ, LZ, LZ, 7'h40}, -1, 28'h0, 28);
        run_frame("zeros+ld", {LZ, LZ, LZ, LZ, LZ, LZ, 7'h40}, 5, 28'h1234567, 28);
        check("pend after wrap", {31'd0, bus.dbg_pend_flag}, 32'h0);

        // Show 1234567 and load 42 while idx=3
        run_frame("1234567", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78},
                  13, 28'h0000042, 28);

        // Show 42 and load 9999999 on the wrap cycle itself
        run_frame("42", {LZ, LZ, LZ, LZ, LZ, 7'h19, 7'h24}, 27, 28'h9999999, 28);
        check("pend after wrap load", {31'd0, bus.dbg_pend_flag}, 32'h0);

        // Show all nines and load digits with invalid codes
        run_frame("9999999", {7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10},
                  0, 28'h00000AF, 28);
        run_frame("00000AF", {LZ, LZ, LZ, LZ, LZ, 7'h3F, 7'h3F}, -1, 28'h0, 28);

        // Reset mid-slot at idx=5. The outputs must blank without waiting for a clock edge.
        run_frame("pre-rst", {LZ, LZ, LZ, LZ, LZ, 7'h3F, 7'h3F}, -1, 28'h0, 22);
        #2;
        rst = 1'b1;
        #1;
        check("midrst an", {25'd0, bus.an}, 32'h7F);
        check("midrst seg", {25'd0, bus.seg}, 32'h7F);
        check("midrst idx", {29'd0, bus.dbg_idx}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame("post-rst", {LZ, LZ, LZ, LZ, LZ, LZ, 7'h40}, -1, 28'h0, 28);
        check("post-rst pend", {31'd0, bus.dbg_pend_flag}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
